// File: rtl/api_txn_ctrl.sv
// api_txn_ctrl: issues a command downstream, waits a latched window for a response, retries on timeout and reports status
module api_txn_ctrl #(
  parameter int TW = 28,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reg_rst,
  input  logic [TW-1:0] reg_timeout,
  input  logic [RW-1:0] reg_retry,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  output logic          req_start,
  input  logic          resp_valid,
  output logic          busy,
  output logic          done,
  output logic          status_ok,
  output logic          status_timeout,
  output logic [RW-1:0] retry_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t        state;
  logic [TW-1:0] cnt;
  logic [TW-1:0] t_l;
  logic [RW-1:0] r_l;
  assign cmd_ready = state == IDLE && !reg_rst;
  assign busy = state != IDLE;
  // transaction sequencer; soft reset aborts with the same effect as hard reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst || reg_rst) begin
      state          <= IDLE;
      cnt            <= '0;
      t_l            <= '0;
      r_l            <= '0;
      req_start      <= 1'b0;
      done           <= 1'b0;
      status_ok      <= 1'b0;
      status_timeout <= 1'b0;
      retry_cnt      <= '0;
    end else begin
      req_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: if (cmd_valid) begin
          t_l            <= reg_timeout == '0 ? TW'(1) : reg_timeout;
          r_l            <= reg_retry;
          retry_cnt      <= '0;
          status_ok      <= 1'b0;
          status_timeout <= 1'b0;
          req_start      <= 1'b1;
          state          <= ISSUE;
        end
        ISSUE: begin
          cnt   <= TW'(1);
          state <= WAIT;
        end
        WAIT: if (resp_valid) begin
          status_ok <= 1'b1;
          done      <= 1'b1;
          state     <= DONE;
        end else if (cnt >= t_l) begin
          if (retry_cnt < r_l) begin
            retry_cnt <= retry_cnt + 1'b1;
            req_start <= 1'b1;
            state     <= ISSUE;
          end else begin
            status_timeout <= 1'b1;
            done           <= 1'b1;
            state          <= DONE;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_api_txn_ctrl.sv
// tb_api_txn_ctrl: directed transactions with a start/done event scoreboard
module tb_api_txn_ctrl;
  logic        clk = 0;
  logic        rst = 1;
  logic        reg_rst = 0;
  logic [27:0] reg_timeout = 0;
  logic [3:0]  reg_retry = 0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic        req_start;
  logic        resp_valid = 0;
  logic        busy;
  logic        done;
  logic        status_ok;
  logic        status_timeout;
  logic [3:0]  retry_cnt;
  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  typedef struct {int kind; int cyc; int ok; int to; int rc;} ev_t;
  typedef struct {int t; int r; int resp_off; int nstart; int done_off; int ok; int rc; int hold; int chg;} vec_t;
  ev_t q[$];
  vec_t vecs[9] = '{
    '{5, 0, 3, 1, 4, 1, 0, 0, 0},
    '{4, 2, 0, 3, 15, 0, 2, 0, 0},
    '{0, 1, 0, 2, 4, 0, 1, 0, 0},
    '{1, 1, 0, 2, 4, 0, 1, 0, 0},
    '{3, 1, 3, 1, 4, 1, 0, 0, 0},
    '{2, 3, 4, 2, 5, 1, 1, 0, 0},
    '{3, 0, 0, 1, 4, 0, 0, 1, 0},
    '{10, 0, 0, 1, 11, 0, 0, 0, 1},
    '{6, 2, 0, 3, 21, 0, 2, 1, 0}
  };

  api_txn_ctrl dut (
    .clk(clk), .rst(rst), .reg_rst(reg_rst), .reg_timeout(reg_timeout),
    .reg_retry(reg_retry), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .req_start(req_start), .resp_valid(resp_valid), .busy(busy), .done(done),
    .status_ok(status_ok), .status_timeout(status_timeout), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    nvec++;
    if (a != e) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic mon_ev(input int kind);
    nvec++;
    if (q.size() == 0 || q[0].kind != kind || q[0].cyc != cyc) begin
      nerr++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d expected %0s", kind ? "done" : "req_start", cyc,
               q.size() == 0 ? "none" : $sformatf("kind %0d at cycle %0d", q[0].kind, q[0].cyc));
    end else begin
      if (kind == 1) begin
        chk("done_status_ok", int'(status_ok), q[0].ok);
        chk("done_status_timeout", int'(status_timeout), q[0].to);
        chk("done_retry_cnt", int'(retry_cnt), q[0].rc);
      end
      void'(q.pop_front());
    end
  endtask

  // monitor: retire expected events against observed pulses
  always @(negedge clk) if (!rst) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      nvec++;
      nerr++;
      $display("FAIL missed_event: got nothing expected kind %0d at cycle %0d", q[0].kind, q[0].cyc);
      void'(q.pop_front());
    end
    if (req_start) mon_ev(0);
    if (done) mon_ev(1);
  end

  task automatic run(input vec_t v);
    int s, p;
    @(negedge clk);
    s = cyc + 1;
    p = 1 + (v.t == 0 ? 1 : v.t);
    for (int k = 0; k < v.nstart; k++) q.push_back('{0, s + k * p, 0, 0, 0});
    q.push_back('{1, s + v.done_off, v.ok, 1 - v.ok, v.rc});
    reg_timeout = 28'(v.t);
    reg_retry = 4'(v.r);
    cmd_valid = 1;
    @(negedge clk);
    if (v.hold == 0) cmd_valid = 0;
    chk("busy_in_txn", int'(busy), 1);
    chk("status_cleared", int'(status_ok | status_timeout), 0);
    while (cyc < s + v.done_off) begin
      resp_valid = v.resp_off != 0 && cyc == s + v.resp_off;
      if (v.chg != 0 && cyc == s + 2) reg_timeout = 28'd2;
      @(negedge clk);
    end
    resp_valid = 0;
    cmd_valid = 0;
    @(negedge clk);
    chk("cmd_ready_after", int'(cmd_ready), 1);
    chk("busy_after", int'(busy), 0);
    chk("hold_status_ok", int'(status_ok), v.ok);
    chk("hold_status_timeout", int'(status_timeout), 1 - v.ok);
    chk("hold_retry_cnt", int'(retry_cnt), v.rc);
  endtask

  initial begin
    int s;
    logic so, st;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_outputs", int'({req_start, done, status_ok, status_timeout, retry_cnt}), 0);
    rst = 0;
    for (int i = 0; i < 9; i++) run(vecs[i]);
    so = status_ok;
    st = status_timeout;
    resp_valid = 1;
    repeat (3) @(negedge clk);
    resp_valid = 0;
    @(negedge clk);
    chk("stray_resp_status_ok", int'(status_ok), int'(so));
    chk("stray_resp_status_timeout", int'(status_timeout), int'(st));
    @(negedge clk);
    s = cyc + 1;
    q.push_back('{0, s, 0, 0, 0});
    reg_timeout = 10;
    reg_retry = 3;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    while (cyc < s + 4) @(negedge clk);
    reg_rst = 1;
    resp_valid = 1;
    #1;
    chk("abort_cmd_ready_gated", int'(cmd_ready), 0);
    chk("abort_busy_before", int'(busy), 1);
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_outputs", int'({req_start, done, status_ok, status_timeout, retry_cnt}), 0);
    reg_rst = 0;
    resp_valid = 0;
    #1;
    chk("abort_cmd_ready", int'(cmd_ready), 1);
    repeat (15) @(negedge clk);
    @(negedge clk);
    s = cyc + 1;
    q.push_back('{0, s, 0, 0, 0});
    reg_timeout = 10;
    reg_retry = 0;
    cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    while (cyc < s + 3) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_cmd_ready", int'(cmd_ready), 1);
    chk("async_rst_outputs", int'({req_start, done, status_ok, status_timeout, retry_cnt}), 0);
    @(negedge clk);
    rst = 0;
    repeat (15) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish within 500000 time units");
    $fatal(1);
  end
endmodule
